bht_ghist_predictor: RTL and testbench
======================================

Name: bht_ghist_predictor

Overview:
- Global-history branch history table (BHT) for the cv32a6 IMAFC Sv32 frontend.
- Sits between the instruction fetch address stage and the frontend branch decision logic.
  - Upstream: fetch address stage, which supplies the fetch virtual PC.
  - Downstream: frontend logic, which consumes one taken/not-taken prediction per compressed-instruction slot.
- Counters are trained from resolved branches coming back from the execute stage.
- Provides a multi-cycle table flush, driven by fence.i or a debug request.

Parameters:
- VLEN, 32, virtual address width.
- NR_ENTRIES, 128, total counter entries; power of two.
- HIST_BITS, 3, global history length; 1..ROW_BITS.
- INSTR_PER_FETCH, 2, halfword slots per 32-bit fetch block (RVC).
- Derived: NR_ROWS=NR_ENTRIES/INSTR_PER_FETCH=64, ROW_BITS=log2(NR_ROWS)=6, OFS=log2(INSTR_PER_FETCH)+1=2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- flush_bht_i  in  1  start table flush sweep.
- vpc_i  in  VLEN  fetch virtual PC for lookup.
- pred_valid_o  out  INSTR_PER_FETCH  per-slot prediction valid.
- pred_taken_o  out  INSTR_PER_FETCH  per-slot predicted taken.
- upd_valid_i  in  1  resolved branch update strobe.
- upd_pc_i  in  VLEN  PC of the resolved branch.
- upd_taken_i  in  1  resolved outcome.
- busy_o  out  1  flush sweep in progress.
- ghist_o  out  HIST_BITS  current global history (debug/trace).
- perf_mispredict_o  out  32  mispredict counter (see Optional Feature).

Behaviour:
- Storage: NR_ROWS x INSTR_PER_FETCH entries. Each entry is {valid, ctr[1:0]}. Held in flops.
- Index:
  - Lookup row = vpc_i[OFS+ROW_BITS-1:OFS] XOR zero-extended ghist.
  - Update row = upd_pc_i[OFS+ROW_BITS-1:OFS] XOR zero-extended ghist (ghist value before this cycle's shift).
  - Update slot = upd_pc_i[OFS-1:1].
- Lookup:
  - Combinational, zero latency, reads registered table state.
  - pred_valid_o[s] = entry.valid & ~busy_o.
  - pred_taken_o[s] = entry.ctr[1] & pred_valid_o[s].
- Update, applied on the clock edge when upd_valid_i=1 and state is IDLE:
  - Entry invalid: valid<=1; ctr<=2'b10 if taken, 2'b01 if not.
  - Entry valid: ctr saturating +1 if taken (max 2'b11), -1 if not taken (min 2'b00).
  - ghist <= {ghist[HIST_BITS-2:0], upd_taken_i}.
- Simultaneous lookup and update of the same entry: lookup returns the pre-update value (no bypass).
- FSM states IDLE and FLUSH:
  - IDLE -> FLUSH when flush_bht_i=1. In that same edge: sweep pointer<=0, ghist<=0. Any concurrent update is dropped; flush wins.
  - In FLUSH, each cycle clears valid and ctr of every slot in row[ptr], then ptr<=ptr+1.
  - FLUSH -> IDLE on the edge that clears row NR_ROWS-1 (ptr wraps to 0).
  - busy_o=1 throughout FLUSH, for exactly NR_ROWS cycles.
- In FLUSH, upd_valid_i is ignored (no table write, no ghist shift) and flush_bht_i is ignored (the sweep is not restarted).
- Reset, including reset mid-flush or mid-update:
  - Every entry's valid=0 and ctr=2'b00.
  - ghist=0, ptr=0, state=IDLE, perf counter=0.
  - Output reset values: pred_valid_o=0, pred_taken_o=0, busy_o=0, ghist_o=0, perf_mispredict_o=0.
- Index wrap: the XOR stays within ROW_BITS. PC bits above the index are ignored, so aliasing is permitted.

Optional Feature:
- Macro: BHT_PERF_CNT_EN.
- Defined:
  - A 32-bit counter increments on each accepted update (IDLE, upd_valid_i=1) where the pre-update predicted direction differs from upd_taken_i.
  - Predicted direction = valid & ctr[1]; an invalid entry counts as predicted not-taken.
  - The counter wraps at 2^32, clears on reset, and is not cleared by flush.
  - Drives perf_mispredict_o.
- Undefined: perf_mispredict_o is tied to 0 and no counter flops exist.

Test Plan:
- Reset, then vpc_i=0x8000_0000 -> pred_valid_o=2'b00, busy_o=0, ghist_o=0.
- Update pc=0x8000_0004, taken=1, from ghist=0 -> row 1 slot 0 becomes ctr=2'b10 and ghist=3'b001.
  - Then lookup vpc_i=0x8000_0005 (row 1^1=0) -> pred_valid_o=0, confirming the index moved with history.
- Three consecutive taken updates to pc=0x8000_0000, with history reset via flush between each -> ctr saturates at 2'b11.
  - Four not-taken updates to the same entry -> ctr=2'b00 and pred_taken_o=0 with pred_valid_o=1.
- Assert flush_bht_i for one cycle with upd_valid_i=1 in the same cycle -> update dropped, busy_o high for exactly 64 cycles.
  - During the sweep, all predictions are invalid and updates are ignored; after it, all entries read invalid.
- Assert rst_i at flush cycle 20 -> next cycle busy_o=0, state IDLE, all entries invalid, ghist_o=0.
- With BHT_PERF_CNT_EN: updates taken, taken, not-taken to a fresh entry with ghist pinned by flush -> perf_mispredict_o=2.
  - Without the macro, perf_mispredict_o reads 0.

Source files
------------

// File: rtl/bht_ghist_predictor_if.sv
// bht_ghist_predictor_if: lookup, training, flush and status signals of the global-history BHT.
// The slave side is the predictor; the master side is fetch/execute (or a testbench).
interface bht_ghist_predictor_if #(
  parameter int unsigned VLEN            = 32,
  parameter int unsigned HIST_BITS       = 3,
  parameter int unsigned INSTR_PER_FETCH = 2
);
  logic                       flush_bht_i;
  logic [VLEN-1:0]            vpc_i;
  logic [INSTR_PER_FETCH-1:0] pred_valid_o;
  logic [INSTR_PER_FETCH-1:0] pred_taken_o;
  logic                       upd_valid_i;
  logic [VLEN-1:0]            upd_pc_i;
  logic                       upd_taken_i;
  logic                       busy_o;
  logic [HIST_BITS-1:0]       ghist_o;
  logic [31:0]                perf_mispredict_o;

  modport master (
    output flush_bht_i, vpc_i, upd_valid_i, upd_pc_i, upd_taken_i,
    input  pred_valid_o, pred_taken_o, busy_o, ghist_o, perf_mispredict_o
  );

  modport slave (
    input  flush_bht_i, vpc_i, upd_valid_i, upd_pc_i, upd_taken_i,
    output pred_valid_o, pred_taken_o, busy_o, ghist_o, perf_mispredict_o
  );
endinterface

// File: rtl/bht_ghist_predictor.sv
// bht_ghist_predictor: gshare-style BHT, 2-bit counters per RVC slot, row-by-row flush sweep.
// Define BHT_PERF_CNT_EN to add the 32-bit mispredict counter on perf_mispredict_o.
module bht_ghist_predictor #(
  parameter int unsigned VLEN            = 32,
  parameter int unsigned NR_ENTRIES      = 128,
  parameter int unsigned HIST_BITS       = 3,
  parameter int unsigned INSTR_PER_FETCH = 2
) (
  input logic                  clk_i,
  input logic                  rst_i,
  bht_ghist_predictor_if.slave bus
);
  localparam int unsigned NR_ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS  = $clog2(NR_ROWS);
  localparam int unsigned SLOT_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned OFS       = SLOT_BITS + 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                     state_q, state_d;
  logic                       valid_q [NR_ROWS][INSTR_PER_FETCH];
  logic [1:0]                 ctr_q   [NR_ROWS][INSTR_PER_FETCH];
  logic [HIST_BITS-1:0]       ghist_q;
  logic [ROW_BITS-1:0]        ptr_q;
  logic                       busy;

  logic [ROW_BITS-1:0]        ghist_ext, lookup_row, upd_row;
  logic [SLOT_BITS-1:0]       upd_slot;
  logic                       flush_start, upd_accept;
  logic                       cur_valid;
  logic [1:0]                 cur_ctr, upd_ctr;
  logic [HIST_BITS:0]         ghist_shift;
  logic [INSTR_PER_FETCH-1:0] pred_valid, pred_taken;
  logic                       unused_pc_bits;

  assign ghist_ext   = ROW_BITS'(ghist_q);
  assign lookup_row  = bus.vpc_i[OFS+ROW_BITS-1:OFS] ^ ghist_ext;
  assign upd_row     = bus.upd_pc_i[OFS+ROW_BITS-1:OFS] ^ ghist_ext;
  assign upd_slot    = bus.upd_pc_i[OFS-1:1];
  assign ghist_shift = {ghist_q, bus.upd_taken_i};
  assign cur_valid   = valid_q[upd_row][upd_slot];
  assign cur_ctr     = ctr_q[upd_row][upd_slot];
  assign flush_start = (state_q == IDLE) && bus.flush_bht_i;
  assign upd_accept  = (state_q == IDLE) && !bus.flush_bht_i && bus.upd_valid_i;

  // PC bits outside the index only alias; they are intentionally dropped.
  assign unused_pc_bits = ^{bus.vpc_i[VLEN-1:OFS+ROW_BITS], bus.vpc_i[OFS-1:0],
                            bus.upd_pc_i[VLEN-1:OFS+ROW_BITS], bus.upd_pc_i[0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.flush_bht_i) state_d = FLUSH;
      FLUSH:   if (ptr_q == ROW_BITS'(NR_ROWS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == FLUSH);
  end

  // A fresh entry starts weakly biased toward the first observed outcome.
  always_comb begin
    upd_ctr = cur_ctr;
    if (!cur_valid)                                upd_ctr = bus.upd_taken_i ? 2'b10 : 2'b01;
    else if (bus.upd_taken_i && cur_ctr != 2'b11)  upd_ctr = cur_ctr + 2'b01;
    else if (!bus.upd_taken_i && cur_ctr != 2'b00) upd_ctr = cur_ctr - 2'b01;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NR_ROWS; r++) begin
        for (int s = 0; s < INSTR_PER_FETCH; s++) begin
          valid_q[r][s] <= 1'b0;
          ctr_q[r][s]   <= 2'b00;
        end
      end
      ghist_q <= '0;
      ptr_q   <= '0;
    end else if (flush_start) begin
      ghist_q <= '0;
      ptr_q   <= '0;
    end else if (state_q == FLUSH) begin
      for (int s = 0; s < INSTR_PER_FETCH; s++) begin
        valid_q[ptr_q][s] <= 1'b0;
        ctr_q[ptr_q][s]   <= 2'b00;
      end
      ptr_q <= ptr_q + ROW_BITS'(1);
    end else if (upd_accept) begin
      valid_q[upd_row][upd_slot] <= 1'b1;
      ctr_q[upd_row][upd_slot]   <= upd_ctr;
      ghist_q                    <= ghist_shift[HIST_BITS-1:0];
    end
  end

  always_comb begin
    pred_valid = '0;
    pred_taken = '0;
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      pred_valid[s] = valid_q[lookup_row][s] & ~busy;
      pred_taken[s] = ctr_q[lookup_row][s][1] & pred_valid[s];
    end
  end

  assign bus.pred_valid_o = pred_valid;
  assign bus.pred_taken_o = pred_taken;
  assign bus.busy_o       = busy;
  assign bus.ghist_o      = ghist_q;

`ifdef BHT_PERF_CNT_EN
  logic [31:0] perf_q;

  // Compares against the pre-update direction; an invalid entry predicts not-taken.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      perf_q <= '0;
    else if (upd_accept && ((cur_valid & cur_ctr[1]) != bus.upd_taken_i))
      perf_q <= perf_q + 32'd1;
  end

  assign bus.perf_mispredict_o = perf_q;
`else
  assign bus.perf_mispredict_o = '0;
`endif

endmodule

// File: tb/tb_bht_ghist_predictor.sv
// tb_bht_ghist_predictor: directed and random stimulus against a table-level model,
// with expected outputs queued per cycle and checked by an independent monitor.
module tb_bht_ghist_predictor;
  localparam int NR_ROWS = 64;
  localparam int IPF     = 2;
  localparam int NR_ENT  = 128;
`ifdef BHT_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]  pv;
    logic [1:0]  pt;
    logic        busy;
    logic [2:0]  ghist;
    logic [31:0] perf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bht_ghist_predictor_if #(.VLEN(32), .HIST_BITS(3), .INSTR_PER_FETCH(2)) bus ();

  bht_ghist_predictor dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  exp_t        exp_q[$];
  int          vectors    = 0;
  int          miscompares = 0;

  int          m_valid[NR_ENT];
  int          m_ctr[NR_ENT];
  int          m_ghist;
  int          m_busy_left;
  int unsigned m_perf;

  function automatic void model_clear();
    for (int i = 0; i < NR_ENT; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
    end
  endfunction

  // PC whose indexed row, under the current model history, lands on target_row.
  function automatic logic [31:0] pcFor(input int target_row, input int slot);
    int r;
    r = (target_row ^ m_ghist) % NR_ROWS;
    return 32'h8000_0000 | 32'(r << 2) | 32'(slot << 1);
  endfunction

  task automatic applyStimulus(input bit r, input bit fl, input logic [31:0] vpc,
                               input bit uv, input logic [31:0] upc, input bit tk,
                               input bit chk);
    exp_t e;
    int   row;
    int   idx;
    @(posedge clk);
    #1;
    rst             = r;
    bus.flush_bht_i = fl;
    bus.vpc_i       = vpc;
    bus.upd_valid_i = uv;
    bus.upd_pc_i    = upc;
    bus.upd_taken_i = tk;
    if (chk) begin
      e.busy = (m_busy_left > 0);
      row    = int'(((vpc >> 2) ^ 32'(m_ghist)) % NR_ROWS);
      for (int s = 0; s < IPF; s++) begin
        e.pv[s] = (m_valid[row*IPF+s] != 0) && !e.busy;
        e.pt[s] = e.pv[s] && (m_ctr[row*IPF+s] >= 2);
      end
      e.ghist = m_ghist[2:0];
      e.perf  = PERF_EN ? m_perf : 32'd0;
      exp_q.push_back(e);
    end
    if (r) begin
      model_clear();
      m_ghist     = 0;
      m_busy_left = 0;
      m_perf      = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (fl) begin
      model_clear();
      m_busy_left = NR_ROWS;
      m_ghist     = 0;
    end else if (uv) begin
      row = int'(((upc >> 2) ^ 32'(m_ghist)) % NR_ROWS);
      idx = row * IPF + int'((upc >> 1) & 32'd1);
      if (((m_valid[idx] != 0) && (m_ctr[idx] >= 2)) != tk) m_perf++;
      if (m_valid[idx] == 0) begin
        m_valid[idx] = 1;
        m_ctr[idx]   = tk ? 2 : 1;
      end else if (tk) begin
        m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
      end else begin
        m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
      end
      m_ghist = ((m_ghist << 1) | int'(tk)) % 8;
    end
  endtask

  task automatic idle(input logic [31:0] vpc);
    applyStimulus(1'b0, 1'b0, vpc, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic update(input logic [31:0] upc, input bit tk);
    applyStimulus(1'b0, 1'b0, 32'h8000_0000, 1'b1, upc, tk, 1'b1);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        cmp("pred_valid", 32'(bus.pred_valid_o), 32'(e.pv));
        cmp("pred_taken", 32'(bus.pred_taken_o), 32'(e.pt));
        cmp("busy", 32'(bus.busy_o), 32'(e.busy));
        cmp("ghist", 32'(bus.ghist_o), 32'(e.ghist));
        cmp("perf_mispredict", bus.perf_mispredict_o, e.perf);
      end
    end
  endtask

  initial checkOutput();

  initial begin
    bus.flush_bht_i = 1'b0;
    bus.vpc_i       = '0;
    bus.upd_valid_i = 1'b0;
    bus.upd_pc_i    = '0;
    bus.upd_taken_i = 1'b0;
    model_clear();
    m_ghist = 0; m_busy_left = 0; m_perf = 0;

    applyStimulus(1'b1, 1'b0, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h8000_0000, 1'b1, 32'h8000_0004, 1'b1, 1'b1);
    idle(32'h8000_0000);

    // First training moves the history, so the same fetch PC indexes a different row.
    update(32'h8000_0004, 1'b1);
    idle(32'h8000_0005);
    idle(32'h8000_0000);
    idle(32'h8000_0004);

    // Saturate one entry upward then downward by steering PCs through the moving history.
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < NR_ROWS; i++) idle(32'h8000_0000 + 32'(i * 4));
    for (int i = 0; i < 3; i++) update(pcFor(0, 0), 1'b1);
    idle(pcFor(0, 0));
    for (int i = 0; i < 4; i++) begin
      update(pcFor(0, 0), 1'b0);
      idle(pcFor(0, 0));
    end

    // Flush with a same-cycle update, then hammer updates and flushes during the sweep.
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_0008, 1'b1, 1'b1);
    for (int i = 0; i < NR_ROWS; i++)
      applyStimulus(1'b0, 1'($urandom_range(0, 3) == 0), $urandom, 1'b1, $urandom, 1'($urandom), 1'b1);
    for (int i = 0; i < 8; i++) idle($urandom);

    // Reset in the middle of a sweep.
    for (int i = 0; i < 6; i++) update($urandom, 1'($urandom));
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) idle($urandom);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle(32'h8000_0000 + 32'(i * 4));

    // Taken, taken, not-taken on a fresh entry: two mispredicts when counting is enabled.
    update(pcFor(5, 1), 1'b1);
    update(pcFor(5, 1), 1'b1);
    update(pcFor(5, 1), 1'b0);
    idle(pcFor(5, 1));

    for (int i = 0; i < 2500; i++) begin
      applyStimulus(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 79) == 0),
                    {$urandom_range(0, 255), 16'h0, 2'($urandom_range(0, 3)), 6'($urandom), 2'($urandom)},
                    1'($urandom), {$urandom_range(0, 255), 16'h0, 2'($urandom_range(0, 3)), 6'($urandom), 2'($urandom)},
                    1'($urandom), 1'b1);
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
